// File: rtl/matrix_loader.sv
// matrix_loader: collects sixteen 16-bit matrix elements into a shadow
// buffer, then swaps them into the active outputs at the next frame_start.
// The active matrix and state code only ever change on a commit, so the
// renderer sees a stable matrix for a whole frame.
module matrix_loader (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic [15:0]  word_in,
  input  logic         word_valid,
  output logic         word_ready,
  input  logic [3:0]   state_in,
  input  logic         load_abort,
  input  logic         frame_start,
  output logic [255:0] mtrxOut,
  output logic [3:0]   matrixState,
  output logic         commit,
  output logic         pending
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [255:0]   shadow_q;
  logic [3:0]     shadow_state_q;
  logic [255:0]   mtrx_q;
  logic [3:0]     mstate_q;
  logic           commit_q;

  logic           xfer;
  logic           last_word;
  logic           do_commit;
  logic [3:0]     wr_idx;
  logic [15:0]    slot_we;

  // An abort wins over a coincident transfer, so the word is dropped.
  assign xfer      = word_valid && word_ready && !load_abort;
  assign last_word = xfer && (state_q == LOAD) && (idx_q == 4'd15);
  // An abort also wins over frame_start: the pending matrix is discarded.
  assign do_commit = (state_q == PEND) && frame_start && !load_abort;
  // The first word of a load always lands in slot 0.
  assign wr_idx    = (state_q == IDLE) ? 4'd0 : idx_q;

  // One write enable per element slot of the shadow buffer.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_slot_we
      assign slot_we[gi] = xfer && (wr_idx == 4'(gi));
    end
  endgenerate

  // State register: FSM state and word index.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: abort dominates, frame_start only matters in PEND.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (load_abort) begin
      state_d = IDLE;
      idx_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            state_d = LOAD;
            idx_d   = 4'd1;
          end
        end
        LOAD: begin
          if (xfer) begin
            // Index 15 wraps naturally to 0 on the last word.
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
              state_d = PEND;
            end
          end
        end
        PEND: begin
          if (frame_start) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 4'd0;
        end
      endcase
    end
  end

  // Output logic decoded from the current state.
  always_comb begin
    word_ready = (state_q != PEND);
    pending    = (state_q == PEND);
  end

  // Shadow buffer: word k goes to bits [255-16k -: 16], stored bit-exact;
  // the state code is captured alongside the last word.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q       <= 256'h0;
      shadow_state_q <= 4'h0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (slot_we[k]) begin
          shadow_q[255-16*k -: 16] <= word_in;
        end
      end
      if (last_word) begin
        shadow_state_q <= state_in;
      end
    end
  end

  // Active outputs: copied from the shadow only at a commit.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      mtrx_q   <= 256'h0;
      mstate_q <= 4'h0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= do_commit;
      if (do_commit) begin
        mtrx_q   <= shadow_q;
        mstate_q <= shadow_state_q;
      end
    end
  end

  assign mtrxOut     = mtrx_q;
  assign matrixState = mstate_q;
  assign commit      = commit_q;

endmodule
